// File: rtl/sel_arbiter.sv
// ---------------------------------------------------------------------------
// sel_arbiter
//
// Round-robin arbiter that drives the select code of a downstream three-way
// selector. A grant is held for at least DWELL cycles. It is released once
// the consumer reports done. A done that arrives early is remembered
// (sticky) until the dwell time has elapsed. Each release is followed by
// exactly one idle gap cycle. All outputs come from registers.
//
// Optional feature macro: SEL_ARB_TIMEOUT_EN
//   defined   -> a grant that runs TIMEOUT cycles without done is released
//                and o_err pulses for one cycle together with o_sel = 2'b11.
//   undefined -> no timeout counter; o_err is tied low and a grant waits for
//                done indefinitely.
//
// Parameters
//   DWELL    minimum grant length in cycles (1..15)
//   TIMEOUT  maximum grant length without done (DWELL..255, macro only)
//
// Ports
//   i_clk   clock; all state changes happen on the rising edge
//   i_rst   synchronous active-high reset, highest priority
//   i_req   per-channel request, bit i requests channel i
//   i_done  downstream consumer has taken the selected word
//   o_sel   selector code, 2'b11 = no channel
//   o_gnt   one-hot copy of o_sel, all zero when o_sel = 2'b11
//   o_busy  high while a grant is held
//   o_err   single-cycle timeout pulse
// ---------------------------------------------------------------------------
module sel_arbiter #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_req,
  input  logic       i_done,
  output logic [1:0] o_sel,
  output logic [2:0] o_gnt,
  output logic       o_busy,
  output logic       o_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_NONE   = 2'b11;
  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  // One-hot form of a selector code; the "no channel" code maps to zero.
  function automatic logic [2:0] f_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    case (sel)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Round-robin pick: search last+1, last+2, last (mod 3).
  // Returns SEL_NONE when nothing is requested.
  function automatic logic [1:0] f_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] order [3];
    logic [1:0] win;
    case (last)
      2'd0: begin
        order[0] = 2'd1;
        order[1] = 2'd2;
        order[2] = 2'd0;
      end
      2'd1: begin
        order[0] = 2'd2;
        order[1] = 2'd0;
        order[2] = 2'd1;
      end
      default: begin
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd2;
      end
    endcase
    win = SEL_NONE;
    for (int k = 2; k >= 0; k--) begin
      if (req[order[k]]) begin
        win = order[k];
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  // Saturating 4-bit increment for the dwell counter.
  function automatic logic [3:0] f_sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;
  logic [3:0] r_dwell;
  logic [3:0] w_dwell_nxt;
  logic       r_done_seen;
  logic       w_done_seen_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [2:0] r_gnt;
  logic       r_busy;
  logic [1:0] w_pick;
  logic       w_release;
  logic       w_tmo_hit;

  assign w_pick    = f_pick(i_req, r_last);
  // Done either now or remembered from earlier in this grant, and the dwell
  // counter has reached its final value.
  assign w_release = (i_done | r_done_seen) && (r_dwell >= DWELL_LAST);

`ifdef SEL_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_tmo;
  logic [7:0] w_tmo_nxt;
  logic       r_err;

  // A grant cycle counts towards the timeout only while no done is known.
  assign w_tmo_hit = !(i_done | r_done_seen) && (r_tmo >= TMO_LAST);

  // Timeout counter: cleared outside GRANT, saturating increment inside.
  always_comb begin
    w_tmo_nxt = 8'd0;
    if ((r_state == GRANT) && (w_state_nxt == GRANT)) begin
      w_tmo_nxt = (r_tmo == 8'hFF) ? r_tmo : r_tmo + 8'd1;
    end else begin
      w_tmo_nxt = 8'd0;
    end
  end

  // Timeout counter and error pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo <= 8'd0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= w_tmo_nxt;
      r_err <= (r_state == GRANT) && !w_release && w_tmo_hit;
    end
  end

  assign o_err = r_err;
`else
  assign w_tmo_hit = 1'b0;
  assign o_err     = 1'b0;
`endif

  // Next-state and next-output logic; everything defaults to the idle view.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_dwell_nxt     = 4'd0;
    w_done_seen_nxt = 1'b0;
    w_sel_nxt       = SEL_NONE;
    case (r_state)
      IDLE: begin
        // done in IDLE is ignored: done_seen stays clear here.
        if (i_req != 3'b000) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_pick;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (w_release || w_tmo_hit) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_sel;
        end else begin
          // Requests may drop during GRANT; the held code does not move.
          w_state_nxt     = GRANT;
          w_sel_nxt       = r_sel;
          w_dwell_nxt     = f_sat_inc4(r_dwell);
          w_done_seen_nxt = r_done_seen | i_done;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, arbitration history, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_last      <= 2'd2;
      r_dwell     <= 4'd0;
      r_done_seen <= 1'b0;
      r_sel       <= SEL_NONE;
      r_gnt       <= 3'b000;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_dwell     <= w_dwell_nxt;
      r_done_seen <= w_done_seen_nxt;
      r_sel       <= w_sel_nxt;
      r_gnt       <= f_onehot(w_sel_nxt);
      r_busy      <= (w_state_nxt == GRANT);
    end
  end

  assign o_sel  = r_sel;
  assign o_gnt  = r_gnt;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_sel_arbiter.sv
// Scoreboard bench for sel_arbiter. The stimulus issues one cycle of inputs
// and queues the hand-computed outputs expected after the next rising edge.
// A monitor on the falling edge pops and compares them. A model of the
// downstream three-way selector checks the integrated y value.
module tb_sel_arbiter;

  typedef struct {
    logic [1:0] sel;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic [2:0] gnt;
  logic       busy;
  logic       err;
  logic [3:0] y;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  sel_arbiter #(.DWELL(4), .TIMEOUT(15)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (req),
    .i_done (done),
    .o_sel  (sel),
    .o_gnt  (gnt),
    .o_busy (busy),
    .o_err  (err)
  );

  always #5 clk = ~clk;

  // Downstream selector: a0=0001, a1=0010, a2=0011, default 0000.
  always_comb begin
    case (sel)
      2'd0:    y = 4'b0001;
      2'd1:    y = 4'b0010;
      2'd2:    y = 4'b0011;
      default: y = 4'b0000;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every falling edge presents one output sample.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [2:0] eg;
      logic [3:0] ey;
      e = q.pop_front();
      case (e.sel)
        2'd0:    begin eg = 3'b001; ey = 4'b0001; end
        2'd1:    begin eg = 3'b010; ey = 4'b0010; end
        2'd2:    begin eg = 3'b100; ey = 4'b0011; end
        default: begin eg = 3'b000; ey = 4'b0000; end
      endcase
      chk("sel",  32'(sel),  32'(e.sel));
      chk("gnt",  32'(gnt),  32'(eg));
      chk("busy", 32'(busy), 32'(e.sel != 2'b11));
      chk("err",  32'(err),  32'(e.err));
      chk("y",    32'(y),    32'(ey));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input logic r, input logic [2:0] rq, input logic d,
                     input logic [1:0] es, input logic ee);
    exp_t e;
    @(negedge clk);
    #1;
    rst  = r;
    req  = rq;
    done = d;
    e.sel = es;
    e.err = ee;
    q.push_back(e);
  endtask

  initial begin
    logic [1:0] order [4];
    order[0] = 2'd0;
    order[1] = 2'd1;
    order[2] = 2'd2;
    order[3] = 2'd0;

    // Reset state.
    cyc(1'b1, 3'b000, 1'b0, 2'b11, 1'b0);
    cyc(1'b1, 3'b111, 1'b1, 2'b11, 1'b0);

    // All requesting, done every cycle: 0,1,2,0, four cycles each, one gap.
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 4; c++) cyc(1'b0, 3'b111, 1'b1, order[g], 1'b0);
      cyc(1'b0, (g == 3) ? 3'b000 : 3'b111, 1'b1, 2'b11, 1'b0);
    end
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);

    // Early done (last=0): channel 1, done in GRANT cycle 0 -> 4 cycles.
    cyc(1'b0, 3'b010, 1'b0, 2'b01, 1'b0);
    cyc(1'b0, 3'b010, 1'b1, 2'b01, 1'b0);
    cyc(1'b0, 3'b010, 1'b0, 2'b01, 1'b0);
    cyc(1'b0, 3'b010, 1'b0, 2'b01, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);

    // Late done (last=1): channel 0, req dropped at cycle 2, done at cycle 7.
    cyc(1'b0, 3'b001, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 7; k++) cyc(1'b0, (k < 2) ? 3'b001 : 3'b000, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, 3'b000, 1'b1, 2'b11, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);

    // Mid-grant reset (last=0): channel 1 granted, reset in cycle 2,
    // the next grant goes to channel 0 because last returns to 2.
    cyc(1'b0, 3'b011, 1'b0, 2'b01, 1'b0);
    cyc(1'b0, 3'b011, 1'b0, 2'b01, 1'b0);
    cyc(1'b0, 3'b011, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 3'b011, 1'b1, 2'b11, 1'b0);
    cyc(1'b0, 3'b011, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'b011, 1'b1, 2'b00, 1'b0);
    cyc(1'b0, 3'b000, 1'b1, 2'b11, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);

    // Channel 2 with done held low (last=0).
    cyc(1'b0, 3'b100, 1'b0, 2'b10, 1'b0);
`ifdef SEL_ARB_TIMEOUT_EN
    for (int k = 0; k < 14; k++) cyc(1'b0, 3'b100, 1'b0, 2'b10, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b1);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);
`else
    for (int k = 0; k < 24; k++) cyc(1'b0, 3'b100, 1'b0, 2'b10, 1'b0);
    cyc(1'b0, 3'b000, 1'b1, 2'b11, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);
`endif

    // done in IDLE is ignored (last=2): grant to 0 must still last until done.
    cyc(1'b0, 3'b000, 1'b1, 2'b11, 1'b0);
    cyc(1'b0, 3'b001, 1'b1, 2'b00, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 3'b001, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, 3'b000, 1'b1, 2'b11, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);

    // Two requesters (last=0): 2 wins, then 0 after the gap.
    cyc(1'b0, 3'b101, 1'b1, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'b101, 1'b1, 2'b10, 1'b0);
    cyc(1'b0, 3'b101, 1'b1, 2'b11, 1'b0);
    cyc(1'b0, 3'b101, 1'b1, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'b101, 1'b1, 2'b00, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 2'b11, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    n_chk++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
